// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: size codes, FSM states,
// byte-enable masks and the data-memory request payload.
package mem_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned BE_W = XLEN / 8;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mem_state_e;

  localparam logic [BE_W-1:0] MASK_B = 8'h01;
  localparam logic [BE_W-1:0] MASK_H = 8'h03;
  localparam logic [BE_W-1:0] MASK_W = 8'h0F;
  localparam logic [BE_W-1:0] MASK_D = 8'hFF;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] wdata;
  } dmem_req_t;

  // Byte-enable mask for an access of the given size at lane 0.
  function automatic logic [BE_W-1:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_B:    return MASK_B;
      SZ_H:    return MASK_H;
      SZ_W:    return MASK_W;
      default: return MASK_D;
    endcase
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] off_mask(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'b000;
      SZ_H:    return 3'b001;
      SZ_W:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/ready port between the MEM stage and data memory.
interface mem_access_stage_if;
  import mem_pkg::*;

  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [BE_W-1:0] dmem_be;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_ready;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/mem_load_align.sv
// Combinational load lane extraction with sign/zero extension to 64 bits.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      offset,
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] data_c
);

  logic [XLEN-1:0] shifted;

  // Move the addressed lane down to bit 0, then truncate and extend.
  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    data_c  = shifted;
    case (size)
      SZ_B:    data_c = is_unsigned ? {56'b0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      SZ_H:    data_c = is_unsigned ? {48'b0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      SZ_W:    data_c = is_unsigned ? {32'b0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: data_c = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: turns load/store controls into a data-memory
// request/ready transaction and stalls upstream until it completes.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (trap misaligned accesses
// instead of forcing the address aligned down).
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               MEM_MemRead,
  input  logic               MEM_MemWrite,
  input  logic [XLEN-1:0]    MEM_ALUOut,
  input  logic [XLEN-1:0]    MEM_WriteData,
  input  logic [1:0]         MEM_Size,
  input  logic               MEM_Unsigned,
  output logic [XLEN-1:0]    MEM_memout,
  output logic               mem_stall,
  output logic               mem_fault,
  mem_access_stage_if.master dmem
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  memout_q, memout_d;
  logic             fault_q, fault_d;

  logic             access_c;
  logic             is_load_c;
  logic             trap_c;
  logic [2:0]       eff_off_c;
  logic [XLEN-1:0]  load_data_c;
  dmem_req_t        req_c;

  assign access_c  = MEM_MemRead | MEM_MemWrite;
  assign is_load_c = MEM_MemRead & ~MEM_MemWrite;
  assign eff_off_c = MEM_ALUOut[2:0] & ~off_mask(MEM_Size);

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap_c = (MEM_ALUOut[2:0] & off_mask(MEM_Size)) != 3'b000;
`else
  assign trap_c = 1'b0;
`endif

  // Lane-aligned request payload, meaningful only while a request is out.
  always_comb begin
    req_c.we    = MEM_MemWrite;
    req_c.addr  = {MEM_ALUOut[XLEN-1:3], 3'b000};
    req_c.be    = BE_W'(size_mask(MEM_Size) << eff_off_c);
    req_c.wdata = MEM_WriteData << {eff_off_c, 3'b000};
  end

  mem_load_align u_load_align (
    .rdata       (dmem.dmem_rdata),
    .offset      (eff_off_c),
    .size        (MEM_Size),
    .is_unsigned (MEM_Unsigned),
    .data_c      (load_data_c)
  );

  // State, wait counter, load result and fault pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      memout_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      memout_q <= memout_d;
      fault_q  <= fault_d;
    end
  end

  // Next-state, timeout counting and load capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    memout_d = memout_q;
    fault_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (access_c) begin
          cnt_d = '0;
          if (trap_c) begin
            state_d = DONE;
            fault_d = 1'b1;
            if (is_load_c) memout_d = '0;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (dmem.dmem_ready) begin
          state_d = DONE;
          if (is_load_c) memout_d = load_data_c;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
          state_d = DONE;
          fault_d = 1'b1;
          if (is_load_c) memout_d = '0;
        end else begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign MEM_memout      = memout_q;
  assign mem_fault       = fault_q;
  assign mem_stall       = access_c & (state_q != DONE);
  assign dmem.dmem_req   = (state_q == BUSY);
  assign dmem.dmem_we    = req_c.we;
  assign dmem.dmem_addr  = req_c.addr;
  assign dmem.dmem_be    = req_c.be;
  assign dmem.dmem_wdata = req_c.wdata;

endmodule
